// File: rtl/boothmult_pkg.sv
// Shared types for the sequential Booth multiplier.
// Define BOOTHMULT_RADIX4_EN to select radix-4 (modified Booth) recoding.
package boothmult_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADD,
        OP_SUB,
        OP_ADD2,
        OP_SUB2
    } op_e;

`ifdef BOOTHMULT_RADIX4_EN
    localparam int RECODE_W = 3;
`else
    localparam int RECODE_W = 2;
`endif

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/booth_recoder.sv
// Booth recoder: low multiplier bits plus Q_1 -> add/sub op code.
// Radix chosen by BOOTHMULT_RADIX4_EN.
module booth_recoder
    import boothmult_pkg::*;
(
    input  logic [RECODE_W-1:0] bits,
    output op_e                 op
);

`ifdef BOOTHMULT_RADIX4_EN
    always_comb begin
        op = OP_NONE;
        unique case (bits)
            3'b001, 3'b010: op = OP_ADD;
            3'b011:         op = OP_ADD2;
            3'b100:         op = OP_SUB2;
            3'b101, 3'b110: op = OP_SUB;
            default:        op = OP_NONE;
        endcase
    end
`else
    always_comb begin
        op = OP_NONE;
        unique case (bits)
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NONE;
        endcase
    end
`endif

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed Booth multiplier, one add/sub-and-shift step per clock.
// BOOTHMULT_RADIX4_EN selects radix-4 steps (ceil(N_LEN/2) cycles).
module booth_multiplier
    import boothmult_pkg::*;
#(
    parameter int N_LEN = 8
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic [N_LEN-1:0]     op1,
    input  logic [N_LEN-1:0]     op2,
    input  logic                 Request,
    output logic [2*N_LEN-1:0]   Result,
    output logic                 Done
);

`ifdef BOOTHMULT_RADIX4_EN
    localparam int QW = N_LEN + (N_LEN % 2);
    localparam int AW = N_LEN + 2;
    localparam int SH = 2;
`else
    localparam int QW = N_LEN;
    localparam int AW = N_LEN + 1;
    localparam int SH = 1;
`endif
    localparam int STEPS = QW / SH;
    localparam int CW    = cnt_w(N_LEN);
    localparam int WW    = AW + QW + 1;

    state_e             state_q, state_d;
    logic [AW-1:0]      a_q, a_d;
    logic [AW-1:0]      m_q, m_d;
    logic [QW-1:0]      q_q, q_d;
    logic               q1_q, q1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*N_LEN-1:0] result_q, result_d;
    logic               done_q, done_d;

    op_e                op;
    logic [RECODE_W-1:0] rec_bits;
    logic [AW-1:0]      addend;
    logic [AW-1:0]      sum;
    logic [WW-1:0]      shifted;
    logic [AW-1:0]      a_sh;
    logic [QW-1:0]      q_sh;
    logic               q1_sh;

`ifdef BOOTHMULT_RADIX4_EN
    assign rec_bits = {q_q[1], q_q[0], q1_q};
`else
    assign rec_bits = {q_q[0], q1_q};
`endif

    booth_recoder u_recoder (
        .bits (rec_bits),
        .op   (op)
    );

    always_comb begin
        addend = '0;
        unique case (op)
            OP_ADD:  addend = m_q;
            OP_SUB:  addend = -m_q;
            OP_ADD2: addend = m_q << 1;
            OP_SUB2: addend = -(m_q << 1);
            default: addend = '0;
        endcase
    end

    // A carries enough guard bits that the shift keeps the true sign.
    assign sum     = a_q + addend;
    assign shifted = $signed({sum, q_q, q1_q}) >>> SH;
    assign a_sh    = shifted[WW-1:QW+1];
    assign q_sh    = shifted[QW:1];
    assign q1_sh   = shifted[0];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        m_d      = m_q;
        q_d      = q_q;
        q1_d     = q1_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (Request) begin
                    m_d     = AW'($signed(op1));
                    a_d     = '0;
                    q_d     = QW'($signed(op2));
                    q1_d    = 1'b0;
                    cnt_d   = CW'(STEPS);
                    done_d  = 1'b0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                a_d   = a_sh;
                q_d   = q_sh;
                q1_d  = q1_sh;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = {a_sh[2*N_LEN-QW-1:0], q_sh};
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            m_q      <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            m_q      <= m_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign Result = result_q;
    assign Done   = done_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier against a plain signed-product model.
// Latency expectation follows BOOTHMULT_RADIX4_EN.
module tb_booth_multiplier;

    localparam int N = 8;
`ifdef BOOTHMULT_RADIX4_EN
    localparam int LAT = (N + 1) / 2;
`else
    localparam int LAT = N;
`endif

    logic           clk = 1'b0;
    logic           n_reset;
    logic [N-1:0]   op1, op2;
    logic           req;
    logic [2*N-1:0] result;
    logic           done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    booth_multiplier #(.N_LEN(N)) dut (
        .Clock   (clk),
        .nReset  (n_reset),
        .op1     (op1),
        .op2     (op2),
        .Request (req),
        .Result  (result),
        .Done    (done)
    );

    function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] a,
                                                input logic [N-1:0] b);
        longint pa, pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return (2*N)'(pa * pb);
    endfunction

    // Accept edge happens inside; returns at the negedge after it.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        op1 = a;
        op2 = b;
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        op1 = N'($urandom);
        op2 = N'($urandom);
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 4 * N; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        n_reset = 1'b0;
        req = 1'b0;
        op1 = '0;
        op2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL reset: done=%b result=%h, want done=0 result=0000",
                     done, result);
        end
        n_reset = 1'b1;
    endtask

    task automatic test_directed;
        logic [N-1:0]   ta [6];
        logic [N-1:0]   tb [6];
        logic [2*N-1:0] te [6];
        int cyc;
        bit ok;
        ta = '{8'h03, 8'h80, 8'h80, 8'hFF, 8'h00, 8'h7F};
        tb = '{8'h05, 8'h80, 8'h7F, 8'hFF, 8'hB3, 8'h7F};
        te = '{16'h000F, 16'h4000, 16'hC080, 16'h0001, 16'h0000, 16'h3F01};
        for (int k = 0; k < 6; k++) begin
            start_op(ta[k], tb[k]);
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL directed_accept[%0d]: done=%b want 0", k, done);
            end
            wait_done(cyc, ok);
            vectors++;
            if (!ok || cyc != LAT) begin
                miscompares++;
                $display("FAIL directed_latency[%0d]: got %0d cycles (ok=%b) want %0d",
                         k, cyc, ok, LAT);
            end
            vectors++;
            if (result !== te[k]) begin
                miscompares++;
                $display("FAIL directed[%0d] %h*%h: result=%h want %h",
                         k, ta[k], tb[k], result, te[k]);
            end
        end
    endtask

    task automatic test_random;
        logic [N-1:0] a, b;
        int cyc;
        bit ok;
        for (int k = 0; k < 10; k++) begin
            a = N'($urandom);
            b = N'($urandom);
            start_op(a, b);
            wait_done(cyc, ok);
            vectors++;
            if (!ok || result !== ref_prod(a, b)) begin
                miscompares++;
                $display("FAIL random[%0d] %h*%h: result=%h ok=%b want %h",
                         k, a, b, result, ok, ref_prod(a, b));
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            vectors++;
            if (done !== 1'b1 || result !== ref_prod(a, b)) begin
                miscompares++;
                $display("FAIL random_hold[%0d]: done=%b result=%h want 1 %h",
                         k, done, result, ref_prod(a, b));
            end
        end
    endtask

    task automatic test_busy_request;
        logic [N-1:0] a, b;
        int cyc;
        bit ok;
        a = 8'h9C;
        b = 8'h37;
        start_op(a, b);
        @(negedge clk);
        op1 = 8'h11;
        op2 = 8'h22;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_done(cyc, ok);
        vectors++;
        if (!ok || cyc + 2 != LAT) begin
            miscompares++;
            $display("FAIL busy_req_latency: got %0d cycles (ok=%b) want %0d",
                     cyc + 2, ok, LAT);
        end
        vectors++;
        if (result !== ref_prod(a, b)) begin
            miscompares++;
            $display("FAIL busy_req: result=%h want %h", result, ref_prod(a, b));
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || result !== ref_prod(a, b)) begin
            miscompares++;
            $display("FAIL busy_req_hold: done=%b result=%h want 1 %h",
                     done, result, ref_prod(a, b));
        end
    endtask

    task automatic test_reset_midop;
        logic [N-1:0] a, b;
        int cyc;
        bit ok;
        start_op(8'h7B, 8'hC5);
        repeat (2) @(negedge clk);
        n_reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL reset_midop: done=%b result=%h want 0 0000", done, result);
        end
        n_reset = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        vectors++;
        if (done !== 1'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL reset_abort: done=%b result=%h want 0 0000", done, result);
        end
        a = 8'hE3;
        b = 8'h45;
        start_op(a, b);
        wait_done(cyc, ok);
        vectors++;
        if (!ok || cyc != LAT || result !== ref_prod(a, b)) begin
            miscompares++;
            $display("FAIL reset_recover: result=%h cyc=%0d ok=%b want %h in %0d",
                     result, cyc, ok, ref_prod(a, b), LAT);
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0]   a, b;
        logic [2*N-1:0] exp_q[$];
        logic [2*N-1:0] exp;
        int cyc;
        bit ok;
        @(negedge clk);
        a = N'($urandom);
        b = N'($urandom);
        op1 = a;
        op2 = b;
        req = 1'b1;
        exp_q.push_back(ref_prod(a, b));
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_accept[%0d]: done=%b want 0", k, done);
            end
            cyc = 0;
            ok  = 1'b0;
            for (int i = 0; i < 4 * N; i++) begin
                @(negedge clk);
                cyc++;
                if (done) begin
                    ok = 1'b1;
                    break;
                end
            end
            exp = exp_q.pop_front();
            vectors++;
            if (!ok || cyc != LAT || result !== exp) begin
                miscompares++;
                $display("FAIL b2b[%0d]: result=%h cyc=%0d ok=%b want %h in %0d",
                         k, result, cyc, ok, exp, LAT);
            end
            a = N'($urandom);
            b = N'($urandom);
            op1 = a;
            op2 = b;
            if (k < 11) exp_q.push_back(ref_prod(a, b));
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_request();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
